tdec_bi: RTL and testbench
==========================

Name: tdec_bi

Overview:
- Receive-side decoder for the bipolar temporal multiplier output used in the tMAC_bi_scaled datapath.
- Consumes the product bitstream and the multiplier's stop flag over one fixed window of 2^WIDTH cycles.
- Converts the bitstream back to a signed binary bipolar value.
- Also recovers the temporal length of operand A, which is the number of cycles with stop low.
- Presents both results on a valid/ready handshake for the downstream binary accumulator.

Parameters:
- WIDTH, 8, log2 of the window length. Window N = 2^WIDTH cycles.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous reset, active-high.
- iStart  input  1  one-cycle pulse aligned with the multiplier's loadA; opens a window.
- iBit  input  1  product bitstream (multiplier oC).
- iStop  input  1  multiplier stop flag.
- oResult  output  WIDTH+2  signed bipolar result, 2*ones - N, range [-N, +N].
- oA_rec  output  WIDTH+1  unsigned count of window cycles with iStop==0.
- oValid  output  1  result valid.
- iReady  input  1  downstream accepts the result.
- oBusy  output  1  high while in RUN.
- oOverrun  output  1  sticky error flag; cleared only by rst.

Behaviour:
- Reset: takes effect on the rising edge with rst=1 and overrides all other inputs. After it:
  - state=IDLE
  - oResult=0, oA_rec=0
  - oValid=0, oBusy=0, oOverrun=0
  - internal cycle, ones and stop-low counters = 0
- FSM states: IDLE, RUN, HOLD.
- IDLE:
  - iStart=1 -> RUN.
  - Clear the cycle counter, ones counter and stop-low counter.
  - The iStart cycle itself is not sampled.
- RUN:
  - Each edge samples iBit and iStop.
  - ones += iBit.
  - alow += ~iStop.
  - cycle counter += 1.
  - Exactly N samples are taken, on the N edges following the iStart edge.
  - The edge that takes sample N does three things:
    - registers oResult = 2*ones_final - N, computed in signed WIDTH+2 arithmetic;
    - registers oA_rec = alow_final;
    - goes to HOLD.
  - Latency: oValid=1 is visible immediately after the edge N cycles after the iStart edge.
  - iStart during RUN is ignored, sets oOverrun, and does not disturb the counters.
  - oBusy=1 only in RUN.
- HOLD:
  - oValid=1; oResult and oA_rec stay stable until accepted.
  - Accept means oValid & iReady at an edge. Then:
    - with iStart=0 -> IDLE, oValid=0;
    - with iStart=1 in the same cycle -> RUN directly, counters cleared, oValid=0 next cycle. No start is lost.
  - iStart without iReady: the start is ignored, oOverrun is set, and the state stays HOLD.
- Output registers: oResult and oA_rec keep their last value in IDLE and RUN. Only oValid qualifies them.
- Width rules:
  - The ones and alow counters are WIDTH+1 bits, so they can reach N without wrapping.
  - The cycle counter is WIDTH+1 bits, or an equivalent terminal-count detect.
  - oResult = +N is representable: 0x100 for WIDTH=8 in a 10-bit signed field.
- iBit and iStop are don't-care outside RUN.
- Reset mid-RUN or mid-HOLD: pending result discarded, no oValid produced, return to IDLE.

Test Plan:
- Full positive: iStart, then iBit=1 and iStop=1 for 256 cycles, iReady=1 -> oValid after 256 cycles; oResult=+256, oA_rec=0; one-cycle oValid.
- Full negative / zero: iBit=0 for 256 cycles -> oResult=-256. Alternating 1,0 -> oResult=0. Exactly 192 ones -> oResult=+128.
- A recovery: iStop=0 for the first 100 sampled cycles, then 1 -> oA_rec=100. Repeat with 0 low cycles -> 0, and with 255 low cycles -> 255.
- Backpressure and overrun:
  - Hold iReady=0 for 10 cycles after oValid -> oResult stable and oValid held.
  - Pulse iStart during that hold -> oOverrun=1, no new window.
  - Then iReady=1 -> IDLE.
- Back-to-back: iStart coincident with the accepting cycle -> second window starts with no gap; second result valid exactly 256 cycles later; oOverrun stays 0.
- Reset mid-RUN: assert rst at cycle 50 of the window -> all outputs 0 on the next edge, no oValid. A fresh iStart then yields a correct full-window result.

Source files
------------

// File: rtl/tdec_bi.sv
// Bipolar temporal-product decoder: counts ones and stop-low cycles over a 2^WIDTH window
// and hands the signed result and recovered A length downstream on valid/ready.
//
// state | meaning
// IDLE  | waiting for iStart; counters held clear
// RUN   | sampling iBit/iStop for N cycles
// HOLD  | result presented, waiting for iReady
module tdec_bi #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iStart,
  input  logic             iBit,
  input  logic             iStop,
  output logic [WIDTH+1:0] oResult,
  output logic [WIDTH:0]   oA_rec,
  output logic             oValid,
  input  logic             iReady,
  output logic             oBusy,
  output logic             oOverrun
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [WIDTH-1:0] CYC_LAST = '1;
  localparam logic [WIDTH+1:0] N_EXT    = {2'b01, {WIDTH{1'b0}}};

  logic [1:0]       state;
  logic [WIDTH-1:0] cyc_left;
  logic [WIDTH:0]   ones;
  logic [WIDTH:0]   alow;
  logic [WIDTH:0]   ones_nxt;
  logic [WIDTH:0]   alow_nxt;
  logic [WIDTH+1:0] result_nxt;

  assign ones_nxt = ones + {{WIDTH{1'b0}}, iBit};
  assign alow_nxt = alow + {{WIDTH{1'b0}}, ~iStop};
  // 2*ones - N wraps correctly into two's complement at WIDTH+2 bits
  assign result_nxt = {ones_nxt, 1'b0} - N_EXT;

  assign oValid = (state == S_HOLD);
  assign oBusy  = (state == S_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cyc_left <= '0;
      ones     <= '0;
      alow     <= '0;
      oResult  <= '0;
      oA_rec   <= '0;
      oOverrun <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          ones     <= '0;
          alow     <= '0;
          cyc_left <= '0;
          if (iStart) begin
            state    <= S_RUN;
            cyc_left <= CYC_LAST;
          end
        end
        S_RUN: begin
          if (iStart) oOverrun <= 1'b1;
          ones <= ones_nxt;
          alow <= alow_nxt;
          if (cyc_left == '0) begin
            oResult <= result_nxt;
            oA_rec  <= alow_nxt;
            state   <= S_HOLD;
          end else begin
            cyc_left <= cyc_left - 1'b1;
          end
        end
        S_HOLD: begin
          if (iReady) begin
            if (iStart) begin
              state    <= S_RUN;
              ones     <= '0;
              alow     <= '0;
              cyc_left <= CYC_LAST;
            end else begin
              state <= S_IDLE;
            end
          end else if (iStart) begin
            oOverrun <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tdec_bi.sv
// Self-checking bench for tdec_bi: table of window patterns plus hand-built sequences
// for backpressure, back-to-back windows and mid-window reset.
module tb_tdec_bi;
  localparam int WIDTH = 8;
  localparam int N = 1 << WIDTH;

  logic clk = 1'b0;
  logic rst, iStart, iBit, iStop, iReady;
  logic [WIDTH+1:0] oResult;
  logic [WIDTH:0]   oA_rec;
  logic oValid, oBusy, oOverrun;

  tdec_bi #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .iStart(iStart), .iBit(iBit), .iStop(iStop),
    .oResult(oResult), .oA_rec(oA_rec), .oValid(oValid), .iReady(iReady),
    .oBusy(oBusy), .oOverrun(oOverrun)
  );

  always #5 clk = ~clk;

  typedef struct { int res; int arec; } exp_t;
  typedef struct { int bk; int bp; int sl; int res; int arec; } vec_t;

  exp_t sb[$];
  vec_t vecs[7];
  bit   pat_bits[N];
  bit   pat_stop[N];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // bk 0: first bp cycles are ones; bk 1: alternating 1,0; bk 2: random.
  // iStop is low for the first sl sampled cycles.
  task automatic build(input int bk, input int bp, input int sl,
                       output int ones, output int low);
    ones = 0;
    low  = 0;
    for (int i = 0; i < N; i++) begin
      case (bk)
        0:       pat_bits[i] = (i < bp);
        1:       pat_bits[i] = (i % 2 == 0);
        default: pat_bits[i] = 1'($urandom_range(0, 1));
      endcase
      pat_stop[i] = !(i < sl);
      ones += int'(pat_bits[i]);
      low  += int'(!pat_stop[i]);
    end
  endtask

  task automatic start_pulse();
    iStart = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_samples();
    for (int i = 0; i < N; i++) begin
      iStart = 1'b0;
      iBit   = pat_bits[i];
      iStop  = pat_stop[i];
      if (i == N / 2) chk("busy_mid_run", int'(oBusy), 1);
      if (i == N - 1) chk("valid_not_early", int'(oValid), 0);
      @(negedge clk);
    end
    iBit  = 1'b0;
    iStop = 1'b1;
  endtask

  task automatic check_result();
    exp_t e;
    int t = 0;
    chk("valid_latency", int'(oValid), 1);
    while (!oValid && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      chk("result", int'($signed(oResult)), e.res);
      chk("a_rec", int'(oA_rec), e.arec);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int ones, low, seen;
    vecs = '{
      '{0, 256,   0,  256,   0},
      '{0,   0,   0, -256,   0},
      '{1,   0,   0,    0,   0},
      '{0, 192,   0,  128,   0},
      '{0, 256, 100,  256, 100},
      '{0,  10, 255, -236, 255},
      '{0, 128, 256,    0, 256}
    };

    rst = 1'b1; iStart = 1'b0; iBit = 1'b0; iStop = 1'b1; iReady = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_result", int'(oResult), 0);
    chk("rst_arec", int'(oA_rec), 0);
    chk("rst_valid", int'(oValid), 0);
    chk("rst_busy", int'(oBusy), 0);
    chk("rst_overrun", int'(oOverrun), 0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[k]) begin
      build(vecs[k].bk, vecs[k].bp, vecs[k].sl, ones, low);
      sb.push_back('{vecs[k].res, vecs[k].arec});
      start_pulse();
      send_samples();
      check_result();
      @(negedge clk);
      chk("valid_one_cycle", int'(oValid), 0);
      chk("result_held_idle", int'($signed(oResult)), vecs[k].res);
    end

    for (int r = 0; r < 3; r++) begin
      build(2, 0, int'($urandom_range(0, N)), ones, low);
      sb.push_back('{2 * ones - N, low});
      start_pulse();
      send_samples();
      check_result();
      @(negedge clk);
    end

    // backpressure with an ignored start while holding
    iReady = 1'b0;
    build(0, 64, 30, ones, low);
    sb.push_back('{-128, 30});
    start_pulse();
    send_samples();
    check_result();
    for (int k = 0; k < 10; k++) begin
      iStart = (k == 4);
      @(negedge clk);
      chk("bp_valid_held", int'(oValid), 1);
      chk("bp_result_stable", int'($signed(oResult)), -128);
      chk("bp_arec_stable", int'(oA_rec), 30);
      chk("bp_no_new_window", int'(oBusy), 0);
    end
    iStart = 1'b0;
    chk("overrun_set", int'(oOverrun), 1);
    iReady = 1'b1;
    @(negedge clk);
    chk("bp_accept_valid", int'(oValid), 0);
    chk("bp_accept_idle", int'(oBusy), 0);
    chk("overrun_sticky", int'(oOverrun), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("overrun_cleared", int'(oOverrun), 0);

    // back-to-back: start coincident with accept
    build(0, 256, 0, ones, low);
    sb.push_back('{256, 0});
    start_pulse();
    send_samples();
    check_result();
    build(1, 0, 77, ones, low);
    sb.push_back('{0, 77});
    iStart = 1'b1;
    @(negedge clk);
    chk("b2b_valid_drop", int'(oValid), 0);
    chk("b2b_busy", int'(oBusy), 1);
    send_samples();
    check_result();
    chk("b2b_no_overrun", int'(oOverrun), 0);
    @(negedge clk);

    // reset 50 samples into a window
    build(0, 256, 0, ones, low);
    start_pulse();
    for (int i = 0; i < 50; i++) begin
      iStart = 1'b0;
      iBit = pat_bits[i];
      iStop = pat_stop[i];
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_result", int'(oResult), 0);
    chk("midrst_arec", int'(oA_rec), 0);
    chk("midrst_valid", int'(oValid), 0);
    chk("midrst_busy", int'(oBusy), 0);
    rst = 1'b0;
    seen = 0;
    repeat (N + 10) begin
      @(negedge clk);
      if (oValid) seen = 1;
    end
    chk("midrst_no_valid", seen, 0);
    build(0, 200, 5, ones, low);
    sb.push_back('{144, 5});
    start_pulse();
    send_samples();
    check_result();
    @(negedge clk);

    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
